// File: rtl/fod_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fod_spi_pkg
// Purpose  : Shared definitions for the FOD SPI configuration register file:
//            FSM state encoding, RW bit encoding, commit-register address
//            helper and the default FOD register map / field positions.
// Revision : 1.0 - initial release
// ============================================================================
package fod_spi_pkg;

    // Frame FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // First bit of every frame
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Default FOD register map (register indices)
    localparam int REG_FCW_LO = 0;
    localparam int REG_FCW_HI = 1;
    localparam int REG_PCALI  = 2;
    localparam int REG_KBCD   = 3;
    localparam int REG_KDTCB  = 4;
    localparam int REG_KDTCC  = 5;
    localparam int REG_KDTCD0 = 6;
    localparam int REG_KDTCD1 = 7;
    localparam int REG_CTRL   = 8;
    localparam int REG_PSEG   = 9;
    localparam int REG_CALEN  = 10;
    localparam int REG_SPARE  = 11;

    // Field positions inside the default registers
    localparam int KBCD_KB_LSB      = 0;
    localparam int KBCD_KC_LSB      = 5;
    localparam int KBCD_KD_LSB      = 10;
    localparam int KBCD_FIELD_W     = 5;
    localparam int CTRL_CAL_EN_BIT  = 0;
    localparam int CTRL_DTC_EN_BIT  = 1;
    localparam int CTRL_PSEG_EN_BIT = 2;

    // Bit of the commit-register data word that requests a shadow->active copy
    localparam int COMMIT_BIT = 0;

    // The topmost address of the address space is the commit register
    function automatic int commit_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fod_spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : fod_spi_sync
// Purpose  : N-stage synchroniser followed by a single-flop edge detector.
// Ports    : clk, rst   - system clock, synchronous active-high reset
//            din        - asynchronous input
//            sync       - synchronised level
//            rise, fall - one-cycle edge strobes of the synchronised level
// Revision : 1.0 - initial release
// ============================================================================
module fod_spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) chain <= RST_VAL;
                else     chain <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) chain <= {STAGES{RST_VAL}};
                else     chain <= {chain[STAGES-2:0], din};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) prev <= RST_VAL;
        else     prev <= chain[STAGES-1];
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/fod_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : fod_spi_regfile
// Purpose  : SPI-slave (CPOL=0/CPHA=0) configuration register file for the
//            FOD controller. Frames write/read shadow registers; shadow is
//            copied atomically to the active registers on an update event.
// Ports    : CLK, RST        - system clock (>= 8x SCK), sync active-high reset
//            SCK, CSN, MOSI  - asynchronous SPI inputs
//            MISO, MISO_OE   - serial read data and its output enable
//            UPDATE          - one-cycle shadow->active copy request
//            CFG_ACTIVE      - flattened active registers
//            UPD_DONE        - one-cycle pulse one cycle after each copy
//            FRAME_ERR       - sticky abort/address error, cleared on frame start
// Revision : 1.0 - initial release
// ============================================================================
module fod_spi_regfile
    import fod_spi_pkg::*;
#(
    parameter int                           ADDR_W      = 4,
    parameter int                           DATA_W      = 16,
    // NUM_REGS must not exceed 2**ADDR_W-1; DATA_W must be >= ADDR_W+1
    parameter int                           NUM_REGS    = 12,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL     = '0,
    parameter int                           SYNC_STAGES = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         SCK,
    input  logic                         CSN,
    input  logic                         MOSI,
    output logic                         MISO,
    output logic                         MISO_OE,
    input  logic                         UPDATE,
    output logic [NUM_REGS*DATA_W-1:0]   CFG_ACTIVE,
    output logic                         UPD_DONE,
    output logic                         FRAME_ERR
);

    localparam int CMD_W   = 1 + ADDR_W;
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [ADDR_W-1:0] NREGS_A  = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] COMMIT_A = ADDR_W'(commit_addr(ADDR_W));

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic sck_s, sck_rise, sck_fall;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    fod_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(CLK), .rst(RST), .din(SCK),  .sync(sck_s),  .rise(sck_rise),  .fall(sck_fall)
    );
    fod_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk(CLK), .rst(RST), .din(CSN),  .sync(csn_s),  .rise(csn_rise),  .fall(csn_fall)
    );
    fod_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(CLK), .rst(RST), .din(MOSI), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the synchronised MOSI level and the SCK edges are consumed
    logic unused_sync;
    assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift;       // bits received so far (only the last DATA_W-1 matter)
    logic [DATA_W-1:0] shift_nxt;   // shift register including the bit arriving now
    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] cmd_addr;
    logic              frame_err;
    logic              int_upd;
    logic              upd_req;
    logic              upd_d1;
    logic              upd_done;

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    assign shift_nxt = {shift, mosi_s};
    assign cmd_addr  = shift_nxt[ADDR_W-1:0];
    // Unimplemented addresses (including the commit register) read as zero
    assign rd_data   = (cmd_addr < NREGS_A) ? shadow[cmd_addr] : '0;
    assign upd_req   = UPDATE | int_upd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            frame_rw   <= RW_WRITE;
            frame_addr <= '0;
            tx         <= '0;
            frame_err  <= 1'b0;
            int_upd    <= 1'b0;
            upd_d1     <= 1'b0;
            upd_done   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= RST_VAL[i*DATA_W +: DATA_W];
                active[i] <= RST_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            int_upd  <= 1'b0;
            upd_d1   <= upd_req;
            upd_done <= upd_d1;

            // Copy reads the pre-write shadow when a frame commits on this same edge
            if (upd_req) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    active[i] <= shadow[i];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state     <= ST_CMD;
                        bit_cnt   <= '0;
                        frame_err <= 1'b0;
                    end
                end

                ST_CMD: begin
                    if (csn_rise) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end else if (sck_rise) begin
                        shift   <= shift_nxt[DATA_W-2:0];
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(CMD_W - 1)) begin
                            state      <= ST_DATA;
                            frame_rw   <= shift_nxt[ADDR_W];
                            frame_addr <= cmd_addr;
                            tx         <= (shift_nxt[ADDR_W] == RW_READ) ? rd_data : '0;
                        end
                    end
                end

                ST_DATA: begin
                    if (csn_rise) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end else if (sck_rise) begin
                        shift   <= shift_nxt[DATA_W-2:0];
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                            state <= ST_DONE;
                            if (frame_rw == RW_WRITE) begin
                                if (frame_addr < NREGS_A)
                                    shadow[frame_addr] <= shift_nxt;
                                else if (frame_addr == COMMIT_A)
                                    int_upd <= shift_nxt[COMMIT_BIT];
                                else
                                    frame_err <= 1'b1;
                            end
                        end
                    end else if (sck_fall && (bit_cnt > CNT_W'(CMD_W))) begin
                        // The fall right after the last command bit must not
                        // shift: the MSB has to stay up for the first data rise.
                        tx <= {tx[DATA_W-2:0], 1'b0};
                    end
                end

                ST_DONE: begin
                    if (csn_s) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MISO      = (state == ST_DATA && frame_rw == RW_READ) ? tx[DATA_W-1] : 1'b0;
    assign MISO_OE   = ~csn_s;
    assign UPD_DONE  = upd_done;
    assign FRAME_ERR = frame_err;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign CFG_ACTIVE[g*DATA_W +: DATA_W] = active[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/fod_spi_regfile.md
Name: fod_spi_regfile

Overview:
- Parametrised SPI-slave configuration register file for the FOD digital controller. It replaces the fixed power-on control settings with runtime-programmable ones.
- The SPI pins are oversampled in the CLK domain. Serial frames write or read shadow registers.
- Shadow contents are copied atomically to the active registers that drive FOD control fields (FCW, calibration enables, KB/KC/KD, KDTC inits, PSEG and similar) on an explicit update event. This enables glitch-free frequency hops.

Parameters:
- ADDR_W, 4, register address width.
- DATA_W, 16, register data width.
- NUM_REGS, 12, number of implemented registers; must be <= 2**ADDR_W - 1. The top address is reserved for the commit register.
- RST_VAL, {NUM_REGS*DATA_W{1'b0}}, flattened per-register reset values. Register i occupies bits [i*DATA_W +: DATA_W].
- SYNC_STAGES, 2, synchroniser depth for SCK, CSN and MOSI.

Ports:
- CLK  in  1  system clock; must be >= 8x the SCK frequency.
- RST  in  1  synchronous active-high reset.
- SCK  in  1  SPI clock, CPOL=0/CPHA=0, asynchronous to CLK.
- CSN  in  1  SPI chip select, active-low, asynchronous.
- MOSI  in  1  SPI serial data in, MSB first.
- MISO  out  1  SPI serial data out.
- MISO_OE  out  1  high while CSN (synchronised) is low.
- UPDATE  in  1  one-cycle pulse: copy shadow to active.
- CFG_ACTIVE  out  NUM_REGS*DATA_W  active register contents, flattened.
- UPD_DONE  out  1  one-cycle pulse after each shadow-to-active copy.
- FRAME_ERR  out  1  sticky abort/address-error flag; cleared on the next valid frame start.

Behaviour:
- Reset (RST high at a CLK edge):
  - shadow and active registers = RST_VAL;
  - FSM = IDLE;
  - MISO = 0, MISO_OE = 0, UPD_DONE = 0, FRAME_ERR = 0;
  - synchronisers are loaded with SCK=0, CSN=1, MOSI=0;
  - a reset during a frame discards that frame.
- Synchronisation and edges:
  - SCK, CSN and MOSI each pass through SYNC_STAGES flops.
  - Edge detect uses one extra flop: rise = sync & ~prev, fall = ~sync & prev.
- Frame format: 1 + ADDR_W + DATA_W bits, MSB first. Bit 0 of the frame is RW (1 = read, 0 = write), followed by ADDR, then DATA.
- FSM states:
  - IDLE: CSN falling edge -> CMD. Bit counter = 0; FRAME_ERR clears.
  - CMD: on each SCK rise, shift MOSI in and increment the counter. After 1+ADDR_W bits, go to DATA. For a read, load the tx shift register with shadow[ADDR], or 0 if ADDR >= NUM_REGS.
  - DATA: on each SCK rise, shift MOSI in. After DATA_W more bits, go to DONE.
  - DONE: write frames commit; wait for CSN high, then return to IDLE.
- Commit rules:
  - Write with ADDR < NUM_REGS: shadow[ADDR] = DATA, one CLK after the last SCK rise.
  - Write with ADDR = 2**ADDR_W-1 and DATA[0] = 1: internal update pulse.
  - Other write addresses: ignored, FRAME_ERR sets.
  - Read frames: no register change.
  - Extra SCK edges in DONE are ignored.
- MISO timing:
  - Read data is driven MSB first during the DATA phase.
  - The tx shift register advances on each synchronised SCK fall, so the first data bit is valid before the first DATA-phase SCK rise.
  - MISO = 0 outside the DATA phase of a read frame.
- Abort: CSN rises before DONE -> no write, FRAME_ERR sets, FSM returns to IDLE.
- Update:
  - UPDATE pulse or internal commit -> active = shadow on the next CLK edge; UPD_DONE pulses one cycle later than that copy.
  - If a shadow write and an update fall on the same cycle, active takes the pre-write shadow value. The write lands in shadow only.
  - Back-to-back UPDATE pulses each copy and each produce an UPD_DONE.
- CFG_ACTIVE changes only on update or reset, never mid-frame.

Decomposition:
- Package fod_spi_pkg:
  - FSM state enum (IDLE, CMD, DATA, DONE);
  - RW encoding constants;
  - commit-register address function;
  - default FOD register map indices and field positions: FCW_LO, FCW_HI, PCALI, KBCD, KDTCB, KDTCC, KDTCD0, KDTCD1, CTRL, and so on.
- One sub-module: fod_spi_sync, an N-stage synchroniser plus edge detector, instanced for SCK, CSN and MOSI.

Test Plan:
- Reset: hold RST 3 cycles with RST_VAL reg0=16'h4000, reg1=16'h0008 -> CFG_ACTIVE low 32 bits = 32'h0008_4000; MISO_OE = 0; UPD_DONE = 0.
- Write then update: frame W addr 2 data 16'hA5C3 -> shadow[2] = A5C3 while CFG_ACTIVE reg2 is unchanged. Pulse UPDATE -> reg2 = A5C3 next edge; UPD_DONE pulses one cycle later.
- Read back: R addr 2 after the previous test -> MISO serialises 1010_0101_1100_0011. R addr 13 -> all zeros; FRAME_ERR stays 0.
- Abort: CSN rises after 10 bits of W addr 3 -> shadow[3] is unchanged; FRAME_ERR = 1. The next valid frame clears it.
- Commit register: W addr 15 data 16'h0001 -> active = shadow, with one UPD_DONE. W addr 15 data 16'h0000 -> no copy.
- Collision and mid-frame reset: UPDATE on the same cycle as a shadow[4] write of 16'h1234 -> active reg4 keeps the old value, shadow = 1234. RST asserted mid-frame -> all registers = RST_VAL and FSM = IDLE; the next full frame completes normally.
